uart_param: RTL

Parametrised full-duplex UART with 16x-oversampled receive, configurable data width, stop bits and parity, and ready/valid handshakes on both byte-side interfaces. It replaces the fixed 9600-8N1 serial block in the wireless-comm path between the radio module's serial pins and the data-logger packet logic. It adds false-start rejection, framing and parity error reporting, and receive overrun detection.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_param.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the uart_param serial block.
// Holds the parity mode enum, both FSM state enums, a frame-length helper
// and the parity-bit helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Total bits on the wire for one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int stop_bits, input int parity);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

  // Parity bit for up to 9 data bits (zero extension does not change the XOR).
  // Even: XOR of the data bits; odd: its inverse.
  function automatic logic par_bit(input logic [8:0] d, input int mode);
    return (mode == int'(ODD)) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing a one-cycle oversample tick
// every DIV clocks (counter runs 0..DIV-1, tick at DIV-1).
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_baud_gen: DIV must be at least 2");
  end

  logic [CW-1:0] cnt;

  // Divider counter, wraps at DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_param.sv
// uart_param: full-duplex UART, 16x (OVERSAMPLE) receive sampling, LSB first.
// Optional parity hardware is built only when UART_PARITY_EN is defined;
// otherwise PARITY is ignored and parity_err is tied low.
// Handshakes (tx_valid/tx_ready, rx_valid/rx_ready): a transfer occurs on
// every rising clk edge where valid and ready are both high; valid, once
// raised, holds with stable data until that transfer.
module uart_param
  import uart_pkg::*;
#(
  parameter int CLOCK      = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA       = 8,
  parameter int STOP       = 1,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic            tx,
  input  logic [DATA-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [DATA-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun,
  output logic [2:0]      rx_state_dbg,
  output logic [2:0]      tx_state_dbg
);

`ifdef UART_PARITY_EN
  localparam int PAR_EFF = PARITY;
`else
  localparam int PAR_EFF = 0;
`endif
  localparam bit PAR_EN     = (PAR_EFF != 0);
  localparam int DIV        = CLOCK / (BAUD * OVERSAMPLE);
  localparam int FRAME_BITS = frame_bits(DATA, STOP, PAR_EFF);
  localparam int CW         = $clog2(OVERSAMPLE);
  localparam int RBW        = $clog2(DATA);
  localparam int TBW        = $clog2(FRAME_BITS);

  if (DATA < 5 || DATA > 9) begin : g_data_check
    $error("uart_param: DATA must be 5..9");
  end
  if (STOP < 1 || STOP > 2) begin : g_stop_check
    $error("uart_param: STOP must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_parity_check
    $error("uart_param: PARITY must be 0, 1 or 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
    $error("uart_param: OVERSAMPLE must be even and at least 8");
  end

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // ---------------- receive ----------------
  logic            rx_m, rx_s, rx_prev;
  rx_state_t       rx_st;
  logic [CW-1:0]   rx_cnt;
  logic [RBW-1:0]  rx_bit;
  logic [DATA-1:0] rx_sh;
  logic            rx_last, rx_ok, rx_bad;
`ifdef UART_PARITY_EN
  logic            rx_perr, perr_q;
`endif

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // Half a bit in START lands mid start bit; every later sample is a full bit on.
  assign rx_last = (rx_st == RX_START) ? (rx_cnt == CW'(OVERSAMPLE / 2 - 1))
                                       : (rx_cnt == CW'(OVERSAMPLE - 1));
  assign rx_ok   = (rx_st == RX_STOP) && tick && rx_last && rx_s;
  assign rx_bad  = (rx_st == RX_STOP) && tick && rx_last && !rx_s;

  // Receive FSM: start qualification, data shift, parity and first stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st  <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
`ifdef UART_PARITY_EN
      rx_perr <= 1'b0;
`endif
    end else begin
      case (rx_st)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_st  <= RX_START;
            rx_cnt <= '0;
          end
        end
        RX_BREAK: begin
          if (rx_s) rx_st <= RX_IDLE;
        end
        default: begin
          if (tick) begin
            if (rx_last) begin
              rx_cnt <= '0;
              case (rx_st)
                RX_START: begin
                  rx_bit <= '0;
`ifdef UART_PARITY_EN
                  rx_perr <= 1'b0;
`endif
                  rx_st  <= rx_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                  rx_sh <= {rx_s, rx_sh[DATA-1:1]};
                  if (rx_bit == RBW'(DATA - 1)) begin
                    rx_st <= PAR_EN ? RX_PARITY : RX_STOP;
                  end else begin
                    rx_bit <= rx_bit + 1'b1;
                  end
                end
                RX_PARITY: begin
`ifdef UART_PARITY_EN
                  rx_perr <= (rx_s != par_bit(9'(rx_sh), PAR_EFF));
`endif
                  rx_st <= RX_STOP;
                end
                default: begin
                  // Stop sample: go idle mid stop bit, or hold off on a break.
                  rx_st <= rx_s ? RX_IDLE : RX_BREAK;
                end
              endcase
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Output holding register with overrun detection and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      frame_err <= rx_bad;
      overrun   <= rx_ok && rx_valid && !rx_ready;
      if (rx_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
`ifdef UART_PARITY_EN
        perr_q   <= rx_perr;
`endif
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  // ---------------- transmit ----------------
  tx_state_t       tx_st;
  logic [CW-1:0]   tx_cnt;
  logic [TBW-1:0]  tx_bit;
  logic [DATA-1:0] tx_sh;
  logic            tx_par, tx_wait;

  // Transmit FSM: tx_bit indexes the wire bit being sent (0 = start); each
  // bit boundary picks the next state from that index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st    <= TX_IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_wait  <= 1'b0;
    end else if (tx_st == TX_IDLE) begin
      if (tx_valid) begin
        tx_sh    <= tx_data;
        tx_par   <= par_bit(9'(tx_data), PAR_EFF);
        tx_ready <= 1'b0;
        tx_wait  <= 1'b1;
        tx_cnt   <= '0;
        tx_bit   <= '0;
        tx_st    <= TX_START;
      end
    end else if (tick) begin
      if (tx_wait) begin
        tx_wait <= 1'b0;
        tx      <= 1'b0;
      end else if (tx_cnt == CW'(OVERSAMPLE - 1)) begin
        tx_cnt <= '0;
        tx_bit <= tx_bit + 1'b1;
        if (tx_bit == TBW'(FRAME_BITS - 1)) begin
          tx_st    <= TX_IDLE;
          tx_ready <= 1'b1;
        end else if (tx_bit < TBW'(DATA)) begin
          tx_st <= TX_DATA;
          tx    <= tx_sh[0];
          tx_sh <= tx_sh >> 1;
        end else if (PAR_EN && (tx_bit == TBW'(DATA))) begin
          tx_st <= TX_PARITY;
          tx    <= tx_par;
        end else begin
          tx_st <= TX_STOP;
          tx    <= 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  assign rx_state_dbg = rx_st;
  assign tx_state_dbg = tx_st;

endmodule
